// File: rtl/crc_pkg.sv
// crc_pkg: shared state encoding, default widths and drain length for the CRC-16 transmit path.
package crc_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int CRC_W_DEF = 16;
  localparam int DRAIN_EXTRA = 2;
  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, CAPTURE, HOLD, DRAIN} state_e;
  function automatic int drain_len(input int crc_w);
    return crc_w + DRAIN_EXTRA;
  endfunction
endpackage

// File: rtl/crc16_engine.sv
// crc16_engine: serial reflected CRC-16 (poly 0x8408), streams the remainder LSB first once start falls.
module crc16_engine import crc_pkg::*; (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_n_i,
  input  logic start_i,
  input  logic data_i,
  output logic bit_o,
  output logic done_o
);
  logic [15:0] crc_q, sh_q;
  logic [3:0] cnt_q;
  logic armed_q, active_q;
  // Coming out of reset the engine replays a junk done burst, as the real part does.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      crc_q <= '0;
      sh_q <= 16'hA5A5;
      cnt_q <= '0;
      armed_q <= 1'b0;
      active_q <= 1'b1;
    end else if (!clr_n_i) begin
      crc_q <= '0;
      cnt_q <= '0;
      armed_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      if (active_q) begin
        sh_q <= sh_q >> 1;
        cnt_q <= cnt_q + 1'b1;
        active_q <= cnt_q != 4'd15;
      end
      if (start_i) begin
        crc_q <= (crc_q >> 1) ^ ((crc_q[0] ^ data_i) ? CRC16_POLY_REFL : 16'h0000);
        armed_q <= 1'b1;
      end else if (armed_q) begin
        sh_q <= crc_q;
        cnt_q <= '0;
        armed_q <= 1'b0;
        active_q <= 1'b1;
      end
    end
  assign bit_o = sh_q[0];
  assign done_o = active_q;
endmodule

// File: rtl/crc16_tx_feeder.sv
// crc16_tx_feeder: serialises payload bytes LSB first into a CRC engine and captures the streamed remainder.
module crc16_tx_feeder import crc_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CRC_W = CRC_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              crc_clr_n,
  output logic              crc_start,
  output logic              crc_data,
  input  logic              crc_bit,
  input  logic              crc_done,
  output logic [CRC_W-1:0]  crc_word,
  output logic              crc_valid,
  input  logic              crc_ack,
  output logic              busy,
  output logic              err
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  localparam int DL = drain_len(CRC_W);
  localparam int CW = $clog2(DL);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CRC_W - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DL - 1);
  state_e state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CRC_W-1:0] word_q, word_d;
  logic last_q, last_d, low_q, low_d, err_q, err_d, run_q;
  logic at_end;
  assign at_end = state_q == SHIFT && bit_q == BIT_LAST;
  // run_q keeps s_ready low while reset is held, even though the state already reads IDLE.
  assign s_ready = run_q && (state_q == IDLE || (at_end && !last_q));
  assign crc_clr_n = state_q != CLEAR;
  assign crc_start = state_q == SHIFT;
  assign crc_data = crc_start && sr_q[0];
  assign crc_word = word_q;
  assign crc_valid = state_q == HOLD;
  assign busy = state_q != IDLE;
  assign err = err_q;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    last_d = last_q;
    bit_d = bit_q;
    cnt_d = cnt_q;
    low_d = low_q;
    word_d = word_q;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (s_valid && s_ready) begin
        sr_d = s_data;
        last_d = s_last;
        state_d = CLEAR;
      end
      CLEAR: begin
        bit_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d = sr_q >> 1;
        bit_d = bit_q + 1'b1;
        if (at_end) begin
          bit_d = '0;
          cnt_d = '0;
          low_d = 1'b0;
          if (last_q) state_d = CAPTURE;
          else if (s_valid) begin
            sr_d = s_data;
            last_d = s_last;
          end else begin
            err_d = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      // Remainder shifts in from the top so the first bit lands in bit 0 after CRC_W bits.
      CAPTURE: if (crc_done) begin
        word_d = {crc_bit, word_q[CRC_W-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CAP_LAST) begin
          cnt_d = '0;
          low_d = 1'b0;
          state_d = HOLD;
        end
      end else if (cnt_q != '0 || low_q) begin
        err_d = 1'b1;
        cnt_d = '0;
        low_d = 1'b0;
        state_d = IDLE;
      end else low_d = 1'b1;
      HOLD: if (crc_ack) state_d = IDLE;
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q <= '0;
      last_q <= 1'b0;
      bit_q <= '0;
      cnt_q <= '0;
      low_q <= 1'b0;
      word_q <= '0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      last_q <= last_d;
      bit_q <= bit_d;
      cnt_q <= cnt_d;
      low_q <= low_d;
      word_q <= word_d;
      err_q <= err_d;
      run_q <= 1'b1;
    end
endmodule
